// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep checker for a Skolem function: walks every input vector,
// waits LAT cycles for the function to settle, then compares its output
// against a golden model and records the mismatch count and first failure.
module skolem_sweep_checker #(
    parameter int unsigned NIN   = 8,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [NIN-1:0]   vec_o,
    input  logic             dut_out_i,
    input  logic             gold_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic [NIN-1:0]   first_vec_o,
    output logic             first_valid_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [NIN-1:0]    vec_q, vec_d;
    logic [NIN-1:0]    first_vec_q, first_vec_d;
    logic              first_valid_q, first_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              mismatch;

    assign mismatch = dut_out_i ^ gold_out_i;

    // State and result registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            vec_q         <= '0;
            first_vec_q   <= '0;
            first_valid_q <= 1'b0;
            cnt_q         <= '0;
            pass_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            vec_q         <= vec_d;
            first_vec_q   <= first_vec_d;
            first_valid_q <= first_valid_d;
            cnt_q         <= cnt_d;
            pass_q        <= pass_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    // Next-state and result update; abort overrides any CHECK update
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        vec_d         = vec_q;
        first_vec_d   = first_vec_q;
        first_valid_d = first_valid_q;
        cnt_d         = cnt_q;
        pass_d        = pass_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d       = S_WAIT;
                    vec_d         = '0;
                    cnt_d         = '0;
                    first_valid_d = 1'b0;
                    first_vec_d   = '0;
                    pass_d        = 1'b0;
                    wait_d        = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (abort_i) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (wait_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_CHECK: begin
                if (abort_i) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    if (mismatch) begin
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (!first_valid_q) begin
                            first_vec_d   = vec_q;
                            first_valid_d = 1'b1;
                        end
                    end
                    if (vec_q != '1) begin
                        vec_d   = vec_q + NIN'(1);
                        wait_d  = WAIT_INIT;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (abort_i) begin
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    pass_d = (cnt_q == '0);
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign vec_o          = vec_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign aborted_o      = aborted_q;
    assign pass_o         = pass_q;
    assign mismatch_cnt_o = cnt_q;
    assign first_vec_o    = first_vec_q;
    assign first_valid_o  = first_valid_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench: u0 is NIN=8/LAT=1/CNT_W=9, u1 is NIN=8/LAT=3/CNT_W=8.
module tb_skolem_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] start_v = 2'b00;
    logic [1:0] abort_v = 2'b00;
    int         mode0 = 0;
    int         mode1 = 0;
    int         sel = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] vec0, vec1, fvec0, fvec1;
    logic [8:0] cnt0;
    logic [7:0] cnt1;
    logic       busy0, busy1, done0, done1, ab0, ab1, pass0, pass1, fval0, fval1;
    logic       dout0, dout1, gold0, gold1;
    logic       busy_s, done_s, ab_s;

    always #5 clk = ~clk;

    // Injected golden-model disagreement per scenario
    function automatic logic inject(input int m, input logic [7:0] v);
        case (m)
            1:       return (v == 8'h2A) || (v == 8'hF0);
            2:       return 1'b1;
            3:       return (v == 8'hFF);
            default: return 1'b0;
        endcase
    endfunction

    assign dout0 = ^vec0;
    assign dout1 = ^vec1;
    assign gold0 = dout0 ^ inject(mode0, vec0);
    assign gold1 = dout1 ^ inject(mode1, vec1);

    assign busy_s = (sel == 1) ? busy1 : busy0;
    assign done_s = (sel == 1) ? done1 : done0;
    assign ab_s   = (sel == 1) ? ab1   : ab0;

    skolem_sweep_checker #(.NIN(8), .LAT(1), .CNT_W(9)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .abort_i(abort_v[0]),
        .vec_o(vec0), .dut_out_i(dout0), .gold_out_i(gold0),
        .busy_o(busy0), .done_o(done0), .aborted_o(ab0), .pass_o(pass0),
        .mismatch_cnt_o(cnt0), .first_vec_o(fvec0), .first_valid_o(fval0)
    );

    skolem_sweep_checker #(.NIN(8), .LAT(3), .CNT_W(8)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .abort_i(abort_v[1]),
        .vec_o(vec1), .dut_out_i(dout1), .gold_out_i(gold1),
        .busy_o(busy1), .done_o(done1), .aborted_o(ab1), .pass_o(pass1),
        .mismatch_cnt_o(cnt1), .first_vec_o(fvec1), .first_valid_o(fval1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present start (optionally with abort) for one edge; returns in cycle 1
    task automatic start_sweep(input int s, input logic with_abort);
        sel = s;
        @(negedge clk);
        start_v[s] = 1'b1;
        abort_v[s] = with_abort;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        abort_v[s] = 1'b0;
    endtask

    // Run until busy drops; cycle k is observed #1 after edge k-1
    task automatic run(input int s, input int max_cyc, input int rep_at, input int ab_at,
                       input int rst_at, output int done_cyc, output int ab_cyc,
                       output int done_cnt);
        bit ended = 1'b0;
        done_cyc = 0;
        ab_cyc   = 0;
        done_cnt = 0;
        for (int c = 2; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            if (c == rep_at + 1) start_v[s] = 1'b0;
            if (c == ab_at + 1)  abort_v[s] = 1'b0;
            if (c == rst_at + 1) rst = 1'b0;
            if (done_s) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (ab_s && ab_cyc == 0) ab_cyc = c;
            if (!busy_s) begin
                ended = 1'b1;
                break;
            end
            if (c == rep_at) start_v[s] = 1'b1;
            if (c == ab_at)  abort_v[s] = 1'b1;
            if (c == rst_at) rst = 1'b1;
        end
        check("sweep_terminated", 32'(ended), 32'd1);
    endtask

    int dc, ac, dn;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_cnt", 32'(cnt0), 32'd0);
        check("rst_vec", 32'(vec0), 32'd0);
        check("rst_fvalid", 32'(fval0), 32'd0);
        check("rst_u1_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean sweep with a stray start at cycle 50
        mode0 = 0;
        start_sweep(0, 1'b0);
        check("start_busy", 32'(busy0), 32'd1);
        run(0, 700, 50, 0, 0, dc, ac, dn);
        check("clean_done_cycle", 32'(dc), 32'd513);
        check("clean_done_width", 32'(dn), 32'd1);
        check("clean_no_abort", 32'(ac), 32'd0);
        check("clean_pass", 32'(pass0), 32'd1);
        check("clean_cnt", 32'(cnt0), 32'd0);
        check("clean_fvalid", 32'(fval0), 32'd0);
        check("clean_vec", 32'(vec0), 32'hFF);

        // Two mismatches at 2A and F0
        mode0 = 1;
        start_sweep(0, 1'b0);
        run(0, 700, 0, 0, 0, dc, ac, dn);
        check("two_done_cycle", 32'(dc), 32'd513);
        check("two_cnt", 32'(cnt0), 32'd2);
        check("two_fvec", 32'(fvec0), 32'h2A);
        check("two_fvalid", 32'(fval0), 32'd1);
        check("two_pass", 32'(pass0), 32'd0);

        // Saturation at 255 with every vector mismatching
        mode1 = 2;
        start_sweep(1, 1'b0);
        run(1, 1300, 0, 0, 0, dc, ac, dn);
        check("sat_done_cycle", 32'(dc), 32'd1025);
        check("sat_cnt", 32'(cnt1), 32'd255);
        check("sat_fvec", 32'(fvec1), 32'h00);
        check("sat_pass", 32'(pass1), 32'd0);

        // Single mismatch on the last vector with LAT=3
        mode1 = 3;
        start_sweep(1, 1'b0);
        run(1, 1300, 0, 0, 0, dc, ac, dn);
        check("last_done_cycle", 32'(dc), 32'd1025);
        check("last_cnt", 32'(cnt1), 32'd1);
        check("last_fvec", 32'(fvec1), 32'hFF);
        check("last_pass", 32'(pass1), 32'd0);
        check("last_vec", 32'(vec1), 32'hFF);

        // Abort at cycle 100, which is the CHECK of vec 49
        mode0 = 1;
        start_sweep(0, 1'b0);
        run(0, 700, 0, 100, 0, dc, ac, dn);
        check("abort_cycle", 32'(ac), 32'd101);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_vec_hold", 32'(vec0), 32'h31);
        check("abort_cnt_hold", 32'(cnt0), 32'd1);
        check("abort_fvec_hold", 32'(fvec0), 32'h2A);
        check("abort_pass", 32'(pass0), 32'd0);
        @(posedge clk);
        #1;
        check("abort_pulse_width", 32'(ab0), 32'd0);

        // Restart clears results, then reset at cycle 200
        start_sweep(0, 1'b0);
        check("restart_vec", 32'(vec0), 32'd0);
        check("restart_cnt", 32'(cnt0), 32'd0);
        check("restart_fvalid", 32'(fval0), 32'd0);
        run(0, 700, 0, 0, 200, dc, ac, dn);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_vec", 32'(vec0), 32'd0);
        check("midrst_cnt", 32'(cnt0), 32'd0);
        check("midrst_fvec", 32'(fvec0), 32'd0);
        check("midrst_fvalid", 32'(fval0), 32'd0);
        check("midrst_aborted", 32'(ab0), 32'd0);

        // Abort alone in IDLE does nothing
        @(negedge clk);
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        check("idle_abort_flag", 32'(ab0), 32'd0);
        check("idle_abort_busy", 32'(busy0), 32'd0);

        // Start and abort together in IDLE start the sweep
        mode0 = 0;
        start_sweep(0, 1'b1);
        check("start_abort_busy", 32'(busy0), 32'd1);
        run(0, 700, 0, 0, 0, dc, ac, dn);
        check("post_rst_done_cycle", 32'(dc), 32'd513);
        check("post_rst_pass", 32'(pass0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/skolem_sweep_checker.md
SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 SHALL have parameter NIN, default 8: number of Skolem function inputs (i0..i7 of the function under test); legal range 1..16.
REQ-002 SHALL have parameter LAT, default 1: cycles from a vector change to the sampling of the function outputs; legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 9: width of the mismatch counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state.
REQ-005 rst input 1: synchronous, active-high reset.
REQ-006 start input 1: request one exhaustive sweep; sampled only in IDLE.
REQ-007 abort input 1: terminate the sweep in progress.
REQ-008 vec output NIN: input vector driven to the Skolem function under test and to the golden model.
REQ-009 dut_out input 1: Skolem output (i8) of the function under test for vec.
REQ-010 gold_out input 1: golden-model output for vec.
REQ-011 busy output 1: high in every state except IDLE.
REQ-012 done output 1: one-cycle pulse when a sweep completes.
REQ-013 aborted output 1: one-cycle pulse when a sweep is aborted.
REQ-014 pass output 1: high when the last completed sweep had zero mismatches.
REQ-015 mismatch_cnt output CNT_W: mismatches in the current or last sweep.
REQ-016 first_vec output NIN, first_valid output 1: first mismatching vector, and its valid flag.

Function
REQ-017 SHALL implement states IDLE, WAIT, CHECK and DONE.
REQ-018 IDLE with start=1: next state WAIT; vec<=0, mismatch_cnt<=0, first_valid<=0, first_vec<=0, pass<=0, wait counter<=LAT-1.
REQ-019 IDLE with start=0: all outputs hold.
REQ-020 WAIT: if the wait counter is 0, go to CHECK; otherwise decrement. WAIT therefore lasts exactly LAT cycles per vector.
REQ-021 CHECK lasts one cycle and compares dut_out with gold_out, both combinationally present during that cycle.
REQ-022 Mismatch in CHECK: mismatch_cnt increments, saturating at 2^CNT_W-1. If first_valid=0, first_vec<=vec and first_valid<=1.
REQ-023 CHECK with vec != all-ones: vec<=vec+1, wait counter<=LAT-1, next state WAIT.
REQ-024 CHECK with vec == all-ones: next state DONE; vec holds (no wrap to 0).
REQ-025 DONE lasts one cycle: done=1; pass<=(mismatch_cnt==0) using the final count, including a mismatch on the last vector; next state IDLE.
REQ-026 Each vector costs LAT+1 cycles. With start accepted at edge 0, done is high in cycle 2^NIN*(LAT+1)+1.
REQ-027 abort=1 in WAIT, CHECK or DONE: next state IDLE, aborted=1 for one cycle, done stays 0, pass<=0. Abort takes priority over the CHECK update in the same cycle. mismatch_cnt, first_vec and first_valid hold.
REQ-028 abort in IDLE SHALL be ignored; start while busy SHALL be ignored.
REQ-029 start and abort high together in IDLE: the sweep starts.
REQ-030 Results (pass, mismatch_cnt, first_vec, first_valid, vec) SHALL hold in IDLE until the next accepted start.
REQ-031 done and aborted SHALL never be high in the same cycle.

Reset
REQ-032 rst=1 SHALL force next state IDLE and set vec, busy, done, aborted, pass, mismatch_cnt, first_vec, first_valid and the wait counter to 0, in any state including mid-sweep.
REQ-033 rst SHALL take priority over start and abort.
REQ-034 The first start after reset release SHALL be accepted normally.

Verification
REQ-035 NIN=8, LAT=1, gold_out=dut_out for all vectors, one start pulse -> done in cycle 513, pass=1, mismatch_cnt=0, first_valid=0, vec=8'hFF.
REQ-036 gold_out inverted only for vec 8'h2A and 8'hF0 -> mismatch_cnt=2, first_vec=8'h2A, first_valid=1, pass=0.
REQ-037 CNT_W=8, gold_out=~dut_out always -> mismatch_cnt saturates at 255 (not 256 or 0), first_vec=8'h00, pass=0.
REQ-038 abort at cycle 100 after start -> busy=0 and aborted=1 the next cycle, done never pulses. A new start then restarts from vec=0 with counters cleared.
REQ-039 start repulsed at cycle 50 of a sweep -> no effect on vec or timing. rst at cycle 200 -> all outputs 0 the next cycle, IDLE.
REQ-040 Mismatch only at vec 8'hFF, LAT=3 -> done in cycle 1025, mismatch_cnt=1, pass=0.
